// File: rtl/cla_irl_meta_rd_pkg.sv
// cla_irl_meta_rd_pkg: metadata entry type and read-side FSM states
package cla_irl_meta_rd_pkg;
  typedef struct packed {
    logic [7:0]  class_id;
    logic [15:0] flow_id;
    logic [7:0]  len;
  } cla_irl_meta_type;
  typedef cla_irl_meta_type meta_t;
  typedef enum logic [1:0] {IDLE, RUN, GAP, FLUSH} cla_irl_rd_state_e;
endpackage

// File: rtl/cla_irl_skid2.sv
// cla_irl_skid2: 2-entry in-order register buffer, d0 is the head
module cla_irl_skid2 import cla_irl_meta_rd_pkg::*; (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       wr,
  input  logic       rd,
  input  meta_t      din,
  output meta_t      dout,
  output logic [1:0] occ
);
  meta_t d0, d1;
  logic [1:0] base;
  // slot the incoming entry lands in once this cycle's read has shifted the head
  assign base = occ - {1'b0, rd};
  assign dout = d0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) occ <= '0;
    else occ <= clr ? 2'd0 : occ + {1'b0, wr} - {1'b0, rd};
  always_ff @(posedge clk) begin
    d0 <= (wr && base == 2'd0) ? din : rd ? d1 : d0;
    d1 <= (wr && base == 2'd1) ? din : d1;
  end
endmodule

// File: rtl/cla_irl_meta_rd.sv
// cla_irl_meta_rd: pops classifier->IRL metadata FIFO into a skid buffer with pop gap and flush
module cla_irl_meta_rd import cla_irl_meta_rd_pkg::*; #(
  parameter int GAP_NBITS = 4,
  parameter int CNT_NBITS = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 fifo_empty,
  input  meta_t                fifo_dout,
  output logic                 fifo_rd,
  input  logic                 en,
  input  logic [GAP_NBITS-1:0] gap_cfg,
  input  logic                 flush,
  output logic                 meta_valid,
  output meta_t                meta,
  input  logic                 meta_ready,
  output logic [CNT_NBITS-1:0] pop_count,
  output logic                 busy
);
  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_RUN   = RUN;
  localparam logic [1:0] S_GAP   = GAP;
  localparam logic [1:0] S_FLUSH = FLUSH;
  logic [1:0] state, state_n, occ;
  logic [GAP_NBITS-1:0] gap_cnt;
  logic clr, xfer;
  assign clr        = flush | (state == S_FLUSH);
  assign fifo_rd    = (state == S_FLUSH) ? ~fifo_empty
                    : (state == S_RUN) & ~fifo_empty & (occ < 2'd2) & (gap_cnt == '0);
  assign meta_valid = occ != 2'd0;
  assign xfer       = meta_valid & meta_ready;
  assign busy       = (occ != 2'd0) | (gap_cnt != '0) | (state == S_FLUSH);
  always_comb
    state_n = flush                ? S_FLUSH
            : (state == S_FLUSH)   ? (fifo_empty ? S_IDLE : S_FLUSH)
            : !en                  ? S_IDLE
            : (state == S_IDLE)    ? S_RUN
            : (state == S_RUN)     ? ((fifo_rd && gap_cfg != '0) ? S_GAP : S_RUN)
            : (gap_cnt <= GAP_NBITS'(1)) ? S_RUN : S_GAP;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= S_IDLE;
      gap_cnt   <= '0;
      pop_count <= '0;
    end else begin
      state     <= state_n;
      gap_cnt   <= clr ? '0 : fifo_rd ? gap_cfg : (gap_cnt != '0) ? gap_cnt - GAP_NBITS'(1) : gap_cnt;
      pop_count <= pop_count + CNT_NBITS'(xfer);
    end
  cla_irl_skid2 u_skid (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clr),
    .wr   (fifo_rd & ~clr),
    .rd   (xfer),
    .din  (fifo_dout),
    .dout (meta),
    .occ  (occ)
  );
  a_no_rd_empty: assert property (@(posedge clk) disable iff (!rst_n) !(fifo_rd && fifo_empty));
  a_occ_max:     assert property (@(posedge clk) disable iff (!rst_n) occ <= 2'd2);
  a_hold:        assert property (@(posedge clk) disable iff (!rst_n)
                   (meta_valid && !meta_ready && !flush) |=> (meta_valid && $stable(meta)));
endmodule

// File: tb/tb_cla_irl_meta_rd.sv
// tb_cla_irl_meta_rd: directed table plus hand sequences against a FWFT FIFO model
module tb_cla_irl_meta_rd;
  import cla_irl_meta_rd_pkg::*;
  logic clk, rst_n, f_rst_n, fifo_empty, fifo_rd, en, flush, meta_valid, meta_ready, busy, wr_en;
  meta_t fifo_dout, meta, wr_data;
  logic [3:0] gap_cfg;
  logic [15:0] pop_count;
  meta_t mem [8];
  logic [2:0] wp, rp;
  logic [3:0] fcnt;
  meta_t exp_q [$];
  int pops [$];
  int n_vec = 0, n_err = 0, cyc_n = 0, first_v = -1, seq = 0, exp_total = 0;
  typedef struct {
    int n;
    int gap;
    int spacing;
  } row_t;
  row_t rows [4];

  cla_irl_meta_rd dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .fifo_empty(fifo_empty),
    .fifo_dout (fifo_dout),
    .fifo_rd   (fifo_rd),
    .en        (en),
    .gap_cfg   (gap_cfg),
    .flush     (flush),
    .meta_valid(meta_valid),
    .meta      (meta),
    .meta_ready(meta_ready),
    .pop_count (pop_count),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk or negedge f_rst_n)
    if (!f_rst_n) begin
      wp   <= '0;
      rp   <= '0;
      fcnt <= '0;
    end else begin
      wp   <= wp + 3'(wr_en);
      rp   <= rp + 3'(fifo_rd);
      fcnt <= fcnt + 4'(wr_en) - 4'(fifo_rd);
    end
  always_ff @(posedge clk) if (wr_en) mem[wp] <= wr_data;
  assign fifo_empty = fcnt == 4'd0;
  assign fifo_dout  = mem[rp];

  function automatic meta_t mk(int s);
    meta_t m;
    m.class_id = 8'(s);
    m.flow_id  = 16'(s * 37 + 5);
    m.len      = 8'(255 - s);
    return m;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    meta_t e;
    #1;
    n_vec++;
    if (fifo_rd && fifo_empty) begin
      n_err++;
      $display("FAIL rd_on_empty: fifo_rd=1 with fifo_empty=1 at cycle %0d", cyc_n);
    end
    if (fifo_rd) pops.push_back(cyc_n);
    if (meta_valid && first_v < 0) first_v = cyc_n;
    if (meta_valid && meta_ready) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL extra_xfer: got %0h want none at cycle %0d", meta, cyc_n);
      end else begin
        e = exp_q.pop_front();
        if (meta !== e) begin
          n_err++;
          $display("FAIL data: got %0h want %0h at cycle %0d", meta, e, cyc_n);
        end
      end
    end
    cyc_n++;
    @(negedge clk);
  endtask

  task automatic push();
    wr_en   = 1'b1;
    wr_data = mk(seq);
    exp_q.push_back(wr_data);
    seq++;
    cyc();
    wr_en = 1'b0;
  endtask

  task automatic drain(int b);
    while (exp_q.size() != 0 && b > 0) begin
      cyc();
      b--;
    end
    chk("drain", exp_q.size(), 0);
  endtask

  task automatic wait_idle(int b);
    while (busy && b > 0) begin
      cyc();
      b--;
    end
    chk("idle", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    clk = 0; rst_n = 0; f_rst_n = 0; en = 1; flush = 0; meta_ready = 1;
    wr_en = 0; wr_data = '0; gap_cfg = '0;
    rows[0] = '{8, 0, 1};
    rows[1] = '{4, 3, 4};
    rows[2] = '{3, 1, 2};
    rows[3] = '{2, 15, 16};
    repeat (2) @(negedge clk);
    f_rst_n = 1;
    push();
    push();
    repeat (2) cyc();
    chk("rst_fifo_rd", fifo_rd, 0);
    chk("rst_valid", meta_valid, 0);
    chk("rst_count", pop_count, 0);
    chk("rst_busy", busy, 0);
    f_rst_n = 0;
    exp_q.delete();
    cyc();
    f_rst_n = 1;
    rst_n = 1;
    en = 0;
    cyc();

    foreach (rows[r]) begin
      en = 0;
      gap_cfg = 4'(rows[r].gap);
      meta_ready = 1;
      for (int k = 0; k < rows[r].n; k++) push();
      repeat (2) cyc();
      pops.delete();
      first_v = -1;
      en = 1;
      drain(rows[r].n * rows[r].spacing + 10);
      exp_total += rows[r].n;
      chk("pops", pops.size(), rows[r].n);
      for (int i = 1; i < pops.size(); i++) chk("spacing", pops[i] - pops[i-1], rows[r].spacing);
      chk("latency", pops.size() > 0 ? first_v - pops[0] : -1, 1);
      chk("count", pop_count, exp_total);
      en = 0;
      wait_idle(20);
    end

    en = 0; gap_cfg = '0; meta_ready = 0;
    for (int k = 0; k < 5; k++) push();
    repeat (2) cyc();
    pops.delete();
    en = 1;
    repeat (8) cyc();
    chk("bp_pops", pops.size(), 2);
    chk("bp_rd", fifo_rd, 0);
    chk("bp_valid", meta_valid, 1);
    chk("bp_head", meta, exp_q[0]);
    repeat (3) cyc();
    chk("bp_stable", meta, exp_q[0]);
    meta_ready = 1;
    drain(30);
    exp_total += 5;
    chk("bp_pops_all", pops.size(), 5);
    chk("bp_count", pop_count, exp_total);
    en = 0;
    wait_idle(10);

    meta_ready = 0;
    for (int k = 0; k < 6; k++) push();
    repeat (2) cyc();
    pops.delete();
    en = 1;
    repeat (6) cyc();
    chk("fl_pre_valid", meta_valid, 1);
    flush = 1;
    cyc();
    flush = 0;
    en = 0;
    chk("fl_valid_drop", meta_valid, 0);
    for (int b = 20; (!fifo_empty || busy) && b > 0; b--) cyc();
    exp_q.delete();
    chk("fl_pops", pops.size(), 6);
    chk("fl_empty", fifo_empty, 1);
    chk("fl_busy", busy, 0);
    chk("fl_count", pop_count, exp_total);
    chk("fl_state", dut.state, IDLE);

    en = 1; gap_cfg = '0;
    for (int c = 0; c < 60; c++) begin
      wr_en = 0;
      if (c % 2 == 0 && fcnt < 4'd8) begin
        wr_en   = 1;
        wr_data = mk(seq);
        exp_q.push_back(wr_data);
        seq++;
        exp_total++;
      end
      meta_ready = $urandom_range(0, 3) != 0;
      cyc();
    end
    wr_en = 0;
    meta_ready = 1;
    drain(40);
    chk("eb_count", pop_count, exp_total);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
